// File: rtl/register_file_sb_pkg.sv
// Shared types for the register file with scoreboard.
//   state_t : sequencer state. CLEAR zeroes storage one entry per cycle; RUN serves traffic.
package register_file_sb_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/register_file_sb_if.sv
// Bus bundle for register_file_sb.
//   ready     : clear sequence done, block accepts traffic
//   rd_addr   : NREAD read addresses, port p at [p*AW +: AW]
//   rd_data   : registered read data, port p at [p*N +: N]
//   rd_busy   : registered pending flag per read port
//   we/wr_addr/wr_data    : writeback
//   iss_valid/iss_addr    : decode marks a destination pending
//   iss_ready : combinational issue accept
// master = pipeline side, slave = register file side.
interface register_file_sb_if #(
  parameter int N     = 32,
  parameter int XLEN  = 32,
  parameter int NREAD = 2
);
  localparam int AW = $clog2(XLEN);

  logic                  ready;
  logic [NREAD*AW-1:0]   rd_addr;
  logic [NREAD*N-1:0]    rd_data;
  logic [NREAD-1:0]      rd_busy;
  logic                  we;
  logic [AW-1:0]         wr_addr;
  logic [N-1:0]          wr_data;
  logic                  iss_valid;
  logic [AW-1:0]         iss_addr;
  logic                  iss_ready;

  modport master (
    input  ready, rd_data, rd_busy, iss_ready,
    output rd_addr, we, wr_addr, wr_data, iss_valid, iss_addr
  );

  modport slave (
    output ready, rd_data, rd_busy, iss_ready,
    input  rd_addr, we, wr_addr, wr_data, iss_valid, iss_addr
  );
endinterface

// File: rtl/register_file_scoreboard.sv
// Pending-bit scoreboard: one bit per architectural register, entry 0 never pending.
//   clk, rst   : clock, synchronous active-high reset (clears all pending bits)
//   en         : block is in RUN; when low nothing changes and lookups read 0
//   clr_en/clr_addr   : writeback clears pending
//   iss_valid/iss_addr: issue sets pending; iss_ready is the combinational accept
//   rd_addr    : NREAD lookup addresses; rd_busy is the registered post-edge pending value
module register_file_scoreboard #(
  parameter int XLEN  = 32,
  parameter int NREAD = 2,
  parameter int AW    = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                clr_en,
  input  logic [AW-1:0]       clr_addr,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_addr,
  output logic                iss_ready,
  input  logic [NREAD*AW-1:0] rd_addr,
  output logic [NREAD-1:0]    rd_busy
);

  logic [XLEN-1:0]  pending_q, pending_d;
  logic [NREAD-1:0] busy_q, busy_d;
  logic             clr_hit;

  always_comb begin
    clr_hit   = en && clr_en && (clr_addr == iss_addr);
    // A writeback landing this cycle frees the slot, so a WAW issue may proceed.
    iss_ready = en && ((iss_addr == '0) || !pending_q[iss_addr] || clr_hit);

    pending_d = pending_q;
    if (en && clr_en) pending_d[clr_addr] = 1'b0;
    // Set is applied after clear so a same-cycle issue leaves the register pending.
    if (iss_valid && iss_ready) pending_d[iss_addr] = 1'b1;
    pending_d[0] = 1'b0;

    busy_d = '0;
    for (int unsigned p = 0; p < NREAD; p++) begin
      busy_d[p] = en && pending_d[rd_addr[p*AW +: AW]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      busy_q    <= '0;
    end else begin
      pending_q <= pending_d;
      busy_q    <= busy_d;
    end
  end

  assign rd_busy = busy_q;

endmodule

// File: rtl/register_file_sb.sv
// Register file with NREAD synchronous read ports, one write-first write port and a
// per-register pending scoreboard. Register 0 reads as zero and is never pending.
// After reset a sequencer zeroes registers 1..XLEN-1, one per cycle, before asserting ready.
//   clk : clock
//   rst : synchronous active-high reset, restarts the clear sequence
//   bus : register_file_sb_if slave modport (read, writeback and issue traffic)
module register_file_sb
  import register_file_sb_pkg::*;
#(
  parameter int N     = 32,
  parameter int XLEN  = 32,
  parameter int NREAD = 2
) (
  input  logic           clk,
  input  logic           rst,
  register_file_sb_if.slave bus
);

  localparam int AW = $clog2(XLEN);

  state_t             state_q, state_d;
  logic [AW-1:0]      clr_idx_q, clr_idx_d;
  logic [N-1:0]       regs_q [XLEN];
  logic [N-1:0]       regs_d [XLEN];
  logic [NREAD*N-1:0] rd_data_q, rd_data_d;
  logic               run;

  assign run         = (state_q == ST_RUN);
  assign bus.ready   = run;
  assign bus.rd_data = rd_data_q;

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    regs_d    = regs_q;
    rd_data_d = '0;

    case (state_q)
      ST_CLEAR: begin
        regs_d[clr_idx_q] = '0;
        clr_idx_d         = clr_idx_q + 1'b1;
        if (clr_idx_q == AW'(XLEN - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.we && (bus.wr_addr != '0)) regs_d[bus.wr_addr] = bus.wr_data;
        for (int unsigned p = 0; p < NREAD; p++) begin
          if (bus.rd_addr[p*AW +: AW] == '0)
            rd_data_d[p*N +: N] = '0;
          else if (bus.we && (bus.wr_addr == bus.rd_addr[p*AW +: AW]))
            rd_data_d[p*N +: N] = bus.wr_data;
          else
            rd_data_d[p*N +: N] = regs_q[bus.rd_addr[p*AW +: AW]];
        end
      end
      default: state_d = ST_CLEAR;
    endcase

    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= AW'(1);
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage is zeroed by the clear sequencer rather than by reset.
  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  register_file_scoreboard #(
    .XLEN  (XLEN),
    .NREAD (NREAD),
    .AW    (AW)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .en        (run),
    .clr_en    (bus.we),
    .clr_addr  (bus.wr_addr),
    .iss_valid (bus.iss_valid),
    .iss_addr  (bus.iss_addr),
    .iss_ready (bus.iss_ready),
    .rd_addr   (bus.rd_addr),
    .rd_busy   (bus.rd_busy)
  );

endmodule
